// File: rtl/daq_pkg_scheduler_if.sv
// Pixel-stream and FIFO-write bundle between the line buffer, the package
// scheduler and the async FIFO write port.
interface daq_pkg_scheduler_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 14
);
  logic              pix_valid;
  logic              pix_ready;
  logic [DATA_W-1:0] pix_data;
  logic              pix_sof;
  logic [ADDR_W:0]   fifo_level;
  logic              fifo_full;
  logic              wr_en;
  logic [DATA_W-1:0] din;

  modport slave (
    input  pix_valid, pix_data, pix_sof, fifo_level, fifo_full,
    output pix_ready, wr_en, din
  );

  modport master (
    output pix_valid, pix_data, pix_sof, fifo_level, fifo_full,
    input  pix_ready, wr_en, din
  );
endinterface

// File: rtl/daq_pkg_scheduler.sv
// Write-side package framer for the DAQ_SPI FIFO: admits whole packages only,
// prefixes a 4-byte header, drops packages on low space and pads frame-truncated ones.
module daq_pkg_scheduler #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 14,
  parameter int PKG_PAYLOAD = 4096
) (
  input  logic               wr_clk,
  input  logic               rst_n,
  input  logic               en,
  daq_pkg_scheduler_if.slave bus,
  output logic               pkg_ready,
  output logic [7:0]         frame_cnt,
  output logic [15:0]        drop_cnt,
  output logic               sof_err,
  output logic               ovf_err,
  output logic               busy
);

  localparam int CNT_W = $clog2(PKG_PAYLOAD + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PKG_PAYLOAD - 1);
  localparam logic signed [ADDR_W+1:0] CAPACITY = (ADDR_W+2)'(2 ** ADDR_W);
  localparam logic signed [ADDR_W+1:0] PKG_WORDS = (ADDR_W+2)'(PKG_PAYLOAD + 4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PAYLOAD,
    S_PAD,
    S_DROP,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [1:0]        r_hdr_cnt;
  logic [CNT_W-1:0]  r_beat_cnt;
  logic [7:0]        r_pkg_idx;
  logic [7:0]        r_frame_cnt;
  logic [15:0]       r_drop_cnt;
  logic              r_wr_en;
  logic [DATA_W-1:0] r_din;
  logic              r_pkg_ready;
  logic              r_sof_err;
  logic              r_ovf_err;

  logic signed [ADDR_W+1:0] w_free;
  logic                     w_space_ok;
  logic                     w_sof_hold;
  logic                     w_pix_ready;
  logic                     w_accept;
  logic                     w_cut;

  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

  function automatic logic [DATA_W-1:0] hdr_byte(input logic [1:0] sel,
                                                 input logic [7:0] frame,
                                                 input logic [7:0] idx);
    case (sel)
      2'd0:    return DATA_W'(8'hA5);
      2'd1:    return DATA_W'(8'h5A);
      2'd2:    return DATA_W'(frame);
      default: return DATA_W'(idx);
    endcase
  endfunction

  // Signed so an over-reported level reads as no room rather than wrapping to a huge free count.
  assign w_free     = CAPACITY - $signed({1'b0, bus.fifo_level});
  assign w_space_ok = (w_free >= PKG_WORDS);

  // A new-frame beat in the middle of a package is held back to start the next package.
  assign w_sof_hold = bus.pix_sof && (r_beat_cnt != '0);

  always_comb begin
    w_pix_ready = 1'b0;
    if (r_state == S_PAYLOAD || r_state == S_DROP)
      w_pix_ready = !w_sof_hold;
  end

  assign w_accept = bus.pix_valid && w_pix_ready;
  assign w_cut    = bus.pix_valid && w_sof_hold;

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_hdr_cnt   <= 2'd0;
      r_beat_cnt  <= '0;
      r_pkg_idx   <= 8'd0;
      r_frame_cnt <= 8'd0;
      r_drop_cnt  <= 16'd0;
      r_wr_en     <= 1'b0;
      r_din       <= '0;
      r_pkg_ready <= 1'b0;
      r_sof_err   <= 1'b0;
      r_ovf_err   <= 1'b0;
    end else begin
      r_wr_en     <= 1'b0;
      r_pkg_ready <= 1'b0;
      if (r_wr_en && bus.fifo_full)
        r_ovf_err <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (en && bus.pix_valid) begin
            if (bus.pix_sof) begin
              r_frame_cnt <= r_frame_cnt + 8'd1;
              r_pkg_idx   <= 8'd0;
            end
            r_hdr_cnt  <= 2'd0;
            r_beat_cnt <= '0;
            r_state    <= w_space_ok ? S_HDR : S_DROP;
          end
        end

        S_HDR: begin
          r_wr_en   <= 1'b1;
          r_din     <= hdr_byte(r_hdr_cnt, r_frame_cnt, r_pkg_idx);
          r_hdr_cnt <= r_hdr_cnt + 2'd1;
          if (r_hdr_cnt == 2'd3) begin
            r_beat_cnt <= '0;
            r_state    <= S_PAYLOAD;
          end
        end

        S_PAYLOAD: begin
          if (w_cut) begin
            r_sof_err <= 1'b1;
            r_state   <= S_PAD;
          end else if (w_accept) begin
            r_wr_en    <= 1'b1;
            r_din      <= bus.pix_data;
            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            if (r_beat_cnt == LAST_BEAT)
              r_state <= S_DONE;
          end
        end

        S_PAD: begin
          r_wr_en    <= 1'b1;
          r_din      <= '0;
          r_beat_cnt <= r_beat_cnt + CNT_W'(1);
          if (r_beat_cnt == LAST_BEAT)
            r_state <= S_DONE;
        end

        S_DROP: begin
          if (w_cut || (w_accept && r_beat_cnt == LAST_BEAT)) begin
            r_drop_cnt <= sat_inc16(r_drop_cnt);
            r_pkg_idx  <= r_pkg_idx + 8'd1;
            r_state    <= S_IDLE;
          end else if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
          end
        end

        S_DONE: begin
          r_pkg_ready <= 1'b1;
          r_pkg_idx   <= r_pkg_idx + 8'd1;
          r_state     <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.pix_ready = w_pix_ready;
  assign bus.wr_en     = r_wr_en;
  assign bus.din       = r_din;
  assign pkg_ready     = r_pkg_ready;
  assign frame_cnt     = r_frame_cnt;
  assign drop_cnt      = r_drop_cnt;
  assign sof_err       = r_sof_err;
  assign ovf_err       = r_ovf_err;
  assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_daq_pkg_scheduler.sv
// Bench for daq_pkg_scheduler: drives pixel streams and compares the FIFO write
// stream and status against a package-level reference model.
module tb_daq_pkg_scheduler;
  localparam int DW = 8;
  localparam int AW = 5;
  localparam int P  = 8;
  localparam int CAP = 32;

  logic        wr_clk = 1'b0;
  logic        rst_n  = 1'b0;
  logic        en     = 1'b0;
  logic        pkg_ready;
  logic [7:0]  frame_cnt;
  logic [15:0] drop_cnt;
  logic        sof_err;
  logic        ovf_err;
  logic        busy;

  daq_pkg_scheduler_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  daq_pkg_scheduler #(.DATA_W(DW), .ADDR_W(AW), .PKG_PAYLOAD(P)) dut (
    .wr_clk    (wr_clk),
    .rst_n     (rst_n),
    .en        (en),
    .bus       (bus.slave),
    .pkg_ready (pkg_ready),
    .frame_cnt (frame_cnt),
    .drop_cnt  (drop_cnt),
    .sof_err   (sof_err),
    .ovf_err   (ovf_err),
    .busy      (busy)
  );

  always #5 wr_clk = ~wr_clk;

  int n_checks = 0;
  int n_pass   = 0;

  int         cyc = 0;
  logic [7:0] got_q[$];
  int         wr_cyc_q[$];
  int         rdy_cyc_q[$];

  always @(negedge wr_clk) begin
    cyc++;
    if (bus.wr_en === 1'b1) begin
      got_q.push_back(bus.din);
      wr_cyc_q.push_back(cyc);
    end
    if (pkg_ready === 1'b1) rdy_cyc_q.push_back(cyc);
  end

  // Reference model state
  int         m_frame, m_idx, m_drop, m_pkgs;
  bit         m_sof_err;
  logic [7:0] exp_q[$];
  logic [7:0] st_data[$];
  bit         st_sof[$];
  int         refused_sof;

  task automatic model_reset();
    m_frame = 0; m_idx = 0; m_drop = 0; m_pkgs = 0; m_sof_err = 0;
  endtask

  task automatic clear_run();
    got_q.delete(); wr_cyc_q.delete(); rdy_cyc_q.delete(); exp_q.delete();
    st_data.delete(); st_sof.delete();
    m_pkgs = 0; refused_sof = 0;
  endtask

  // Splits the flat beat stream into packages and produces the expected FIFO bytes.
  task automatic model_stream(input int level);
    int i, n, cnt;
    bit adm;
    i = 0;
    n = st_data.size();
    while (i < n) begin
      if (st_sof[i]) begin
        m_frame = (m_frame + 1) % 256;
        m_idx   = 0;
      end
      adm = (CAP - level) >= (P + 4);
      cnt = 0;
      while (i + cnt < n && cnt < P && !(cnt != 0 && st_sof[i + cnt])) cnt++;
      if (adm) begin
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'(m_frame));
        exp_q.push_back(8'(m_idx));
        for (int k = 0; k < cnt; k++) exp_q.push_back(st_data[i + k]);
        for (int k = cnt; k < P; k++) exp_q.push_back(8'h00);
        if (cnt < P) m_sof_err = 1;
        m_pkgs++;
      end else begin
        m_drop++;
      end
      m_idx = (m_idx + 1) % 256;
      i += cnt;
    end
  endtask

  task automatic drive_stream(input bit gaps);
    int guard;
    bit acc, first;
    for (int i = 0; i < st_data.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(negedge wr_clk);
        bus.pix_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge wr_clk);
      end
      @(negedge wr_clk);
      bus.pix_valid = 1'b1;
      bus.pix_data  = st_data[i];
      bus.pix_sof   = st_sof[i];
      acc = 0; first = 1; guard = 0;
      while (!acc && guard <= 200) begin
        #1;
        acc = (bus.pix_ready === 1'b1);
        if (first && !acc && st_sof[i] && busy === 1'b1) refused_sof++;
        first = 0;
        @(posedge wr_clk);
        if (!acc) begin
          guard++;
          @(negedge wr_clk);
        end
      end
      if (!acc) begin
        n_checks++;
        $display("FAIL drive_timeout: beat %0d not accepted within 200 cycles", i);
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        return;
      end
    end
    @(negedge wr_clk);
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    @(negedge wr_clk);
    while (busy !== 1'b0 && guard < 500) begin
      @(negedge wr_clk);
      guard++;
    end
    if (busy !== 1'b0) begin
      n_checks++;
      $display("FAIL idle_timeout: busy %0b required 0", busy);
    end
    repeat (3) @(negedge wr_clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0;
    bus.pix_valid = 1'b0; bus.pix_sof = 1'b0; bus.pix_data = '0;
    bus.fifo_level = '0; bus.fifo_full = 1'b0;
    repeat (3) @(negedge wr_clk);
    n_checks++; if (bus.wr_en !== 1'b0) $display("FAIL rst_wr_en: got %b required 0", bus.wr_en); else n_pass++;
    n_checks++; if (bus.din !== 8'h00) $display("FAIL rst_din: got %02h required 00", bus.din); else n_pass++;
    n_checks++; if (bus.pix_ready !== 1'b0) $display("FAIL rst_pix_ready: got %b required 0", bus.pix_ready); else n_pass++;
    n_checks++; if (pkg_ready !== 1'b0) $display("FAIL rst_pkg_ready: got %b required 0", pkg_ready); else n_pass++;
    n_checks++; if (frame_cnt !== 8'd0) $display("FAIL rst_frame_cnt: got %0d required 0", frame_cnt); else n_pass++;
    n_checks++; if (drop_cnt !== 16'd0) $display("FAIL rst_drop_cnt: got %0d required 0", drop_cnt); else n_pass++;
    n_checks++; if ({sof_err, ovf_err, busy} !== 3'b000) $display("FAIL rst_flags: got %b required 000", {sof_err, ovf_err, busy}); else n_pass++;
    rst_n = 1'b1;
    model_reset();
    @(negedge wr_clk);
  endtask

  task automatic test_basic();
    int span, rdy_gap;
    clear_run();
    for (int k = 1; k <= P; k++) begin
      st_data.push_back(8'(k));
      st_sof.push_back(k == 1);
    end
    model_stream(0);
    bus.fifo_level = '0;
    en = 1'b1;
    drive_stream(0);
    wait_idle();
    n_checks++;
    if (got_q.size() !== exp_q.size()) $display("FAIL basic_len: got %0d bytes required %0d", got_q.size(), exp_q.size()); else n_pass++;
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      n_checks++;
      if (got_q[k] !== exp_q[k]) $display("FAIL basic_byte%0d: got %02h required %02h", k, got_q[k], exp_q[k]); else n_pass++;
    end
    span    = (wr_cyc_q.size() > 0) ? wr_cyc_q[wr_cyc_q.size()-1] - wr_cyc_q[0] : -1;
    rdy_gap = (wr_cyc_q.size() > 0 && rdy_cyc_q.size() > 0) ? rdy_cyc_q[0] - wr_cyc_q[wr_cyc_q.size()-1] : -1;
    n_checks++; if (span !== P + 3) $display("FAIL basic_back_to_back: got span %0d required %0d", span, P + 3); else n_pass++;
    n_checks++; if (rdy_cyc_q.size() !== 1) $display("FAIL basic_pkg_ready_count: got %0d required 1", rdy_cyc_q.size()); else n_pass++;
    n_checks++; if (rdy_gap !== 1) $display("FAIL basic_pkg_ready_timing: got %0d cycles after last write required 1", rdy_gap); else n_pass++;
    n_checks++; if (frame_cnt !== 8'(m_frame)) $display("FAIL basic_frame_cnt: got %0d required %0d", frame_cnt, m_frame); else n_pass++;
  endtask

  task automatic test_same_frame();
    clear_run();
    for (int k = 9; k <= 16; k++) begin
      st_data.push_back(8'(k));
      st_sof.push_back(1'b0);
    end
    model_stream(0);
    drive_stream(0);
    wait_idle();
    n_checks++;
    if (got_q.size() !== exp_q.size()) $display("FAIL same_frame_len: got %0d required %0d", got_q.size(), exp_q.size()); else n_pass++;
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      n_checks++;
      if (got_q[k] !== exp_q[k]) $display("FAIL same_frame_byte%0d: got %02h required %02h", k, got_q[k], exp_q[k]); else n_pass++;
    end
    n_checks++; if (frame_cnt !== 8'(m_frame)) $display("FAIL same_frame_frame_cnt: got %0d required %0d", frame_cnt, m_frame); else n_pass++;
    n_checks++; if (rdy_cyc_q.size() !== m_pkgs) $display("FAIL same_frame_pkg_ready: got %0d required %0d", rdy_cyc_q.size(), m_pkgs); else n_pass++;
  endtask

  task automatic test_en_gate();
    int busy_seen = 0;
    clear_run();
    en = 1'b0;
    @(negedge wr_clk);
    bus.pix_valid = 1'b1; bus.pix_sof = 1'b1; bus.pix_data = 8'h77;
    repeat (6) begin
      @(negedge wr_clk);
      if (busy !== 1'b0) busy_seen++;
    end
    bus.pix_valid = 1'b0; bus.pix_sof = 1'b0;
    en = 1'b1;
    n_checks++; if (busy_seen + got_q.size() !== 0) $display("FAIL en_gate: got %0d busy cycles and %0d writes required 0", busy_seen, got_q.size()); else n_pass++;
  endtask

  task automatic test_space_drop();
    clear_run();
    for (int k = 0; k < P; k++) begin
      st_data.push_back(8'($urandom_range(1, 255)));
      st_sof.push_back(1'b0);
    end
    model_stream(21);
    bus.fifo_level = 6'd21;
    drive_stream(0);
    wait_idle();
    n_checks++; if (got_q.size() !== 0) $display("FAIL drop_writes: got %0d writes required 0", got_q.size()); else n_pass++;
    n_checks++; if (drop_cnt !== 16'(m_drop)) $display("FAIL drop_cnt: got %0d required %0d", drop_cnt, m_drop); else n_pass++;
    n_checks++; if (rdy_cyc_q.size() !== 0) $display("FAIL drop_pkg_ready: got %0d pulses required 0", rdy_cyc_q.size()); else n_pass++;
  endtask

  task automatic test_boundary_admit();
    clear_run();
    for (int k = 0; k < P; k++) begin
      st_data.push_back(8'($urandom_range(1, 255)));
      st_sof.push_back(1'b0);
    end
    model_stream(20);
    bus.fifo_level = 6'd20;
    drive_stream(0);
    wait_idle();
    n_checks++;
    if (got_q.size() !== exp_q.size()) $display("FAIL boundary_len: got %0d required %0d", got_q.size(), exp_q.size()); else n_pass++;
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      n_checks++;
      if (got_q[k] !== exp_q[k]) $display("FAIL boundary_byte%0d: got %02h required %02h", k, got_q[k], exp_q[k]); else n_pass++;
    end
    n_checks++; if (drop_cnt !== 16'(m_drop)) $display("FAIL boundary_drop_cnt: got %0d required %0d", drop_cnt, m_drop); else n_pass++;
  endtask

  task automatic test_truncation();
    clear_run();
    for (int k = 0; k < 3; k++) begin
      st_data.push_back(8'h31 + 8'(k));
      st_sof.push_back(1'b0);
    end
    for (int k = 0; k < P; k++) begin
      st_data.push_back(8'h40 + 8'(k));
      st_sof.push_back(k == 0);
    end
    model_stream(0);
    bus.fifo_level = '0;
    n_checks++; if (sof_err !== 1'b0) $display("FAIL trunc_sof_err_before: got %b required 0", sof_err); else n_pass++;
    drive_stream(0);
    wait_idle();
    n_checks++;
    if (got_q.size() !== exp_q.size()) $display("FAIL trunc_len: got %0d required %0d", got_q.size(), exp_q.size()); else n_pass++;
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      n_checks++;
      if (got_q[k] !== exp_q[k]) $display("FAIL trunc_byte%0d: got %02h required %02h", k, got_q[k], exp_q[k]); else n_pass++;
    end
    n_checks++; if (refused_sof !== 1) $display("FAIL trunc_sof_not_ready: got %0d refusals required 1", refused_sof); else n_pass++;
    n_checks++; if (sof_err !== 1'b1) $display("FAIL trunc_sof_err: got %b required 1", sof_err); else n_pass++;
    n_checks++; if (rdy_cyc_q.size() !== m_pkgs) $display("FAIL trunc_pkg_ready: got %0d required %0d", rdy_cyc_q.size(), m_pkgs); else n_pass++;
    n_checks++; if (frame_cnt !== 8'(m_frame)) $display("FAIL trunc_frame_cnt: got %0d required %0d", frame_cnt, m_frame); else n_pass++;
  endtask

  task automatic test_random();
    int level, nseg, len;
    bit need_sof;
    for (int it = 0; it < 8; it++) begin
      clear_run();
      level = $urandom_range(0, 26);
      nseg  = $urandom_range(1, 4);
      need_sof = 0;
      for (int s = 0; s < nseg; s++) begin
        len = (s == nseg - 1 || $urandom_range(0, 1) == 0) ? P : $urandom_range(1, P - 1);
        for (int k = 0; k < len; k++) begin
          st_data.push_back(8'($urandom_range(0, 255)));
          st_sof.push_back(k == 0 && (need_sof || $urandom_range(0, 2) == 0));
        end
        need_sof = (len < P);
      end
      model_stream(level);
      bus.fifo_level = 6'(level);
      drive_stream(1);
      wait_idle();
      n_checks++;
      if (got_q.size() !== exp_q.size()) $display("FAIL rand%0d_len: got %0d required %0d", it, got_q.size(), exp_q.size()); else n_pass++;
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
        n_checks++;
        if (got_q[k] !== exp_q[k]) $display("FAIL rand%0d_byte%0d: got %02h required %02h", it, k, got_q[k], exp_q[k]); else n_pass++;
      end
      n_checks++; if (rdy_cyc_q.size() !== m_pkgs) $display("FAIL rand%0d_pkg_ready: got %0d required %0d", it, rdy_cyc_q.size(), m_pkgs); else n_pass++;
      n_checks++; if (drop_cnt !== 16'(m_drop)) $display("FAIL rand%0d_drop_cnt: got %0d required %0d", it, drop_cnt, m_drop); else n_pass++;
      n_checks++; if (frame_cnt !== 8'(m_frame)) $display("FAIL rand%0d_frame_cnt: got %0d required %0d", it, frame_cnt, m_frame); else n_pass++;
      n_checks++; if (sof_err !== m_sof_err) $display("FAIL rand%0d_sof_err: got %b required %b", it, sof_err, m_sof_err); else n_pass++;
    end
  endtask

  task automatic test_overflow();
    clear_run();
    for (int k = 0; k < P; k++) begin
      st_data.push_back(8'($urandom_range(1, 255)));
      st_sof.push_back(1'b0);
    end
    model_stream(0);
    bus.fifo_level = '0;
    n_checks++; if (ovf_err !== 1'b0) $display("FAIL ovf_before: got %b required 0", ovf_err); else n_pass++;
    fork
      drive_stream(0);
      begin
        int guard = 0;
        while (got_q.size() < 6 && guard < 300) begin
          @(negedge wr_clk);
          guard++;
        end
        bus.fifo_full = 1'b1;
        repeat (2) @(negedge wr_clk);
        bus.fifo_full = 1'b0;
      end
    join
    wait_idle();
    n_checks++; if (ovf_err !== 1'b1) $display("FAIL ovf_sticky: got %b required 1", ovf_err); else n_pass++;
    n_checks++;
    if (got_q.size() !== exp_q.size()) $display("FAIL ovf_len: got %0d required %0d", got_q.size(), exp_q.size()); else n_pass++;
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      n_checks++;
      if (got_q[k] !== exp_q[k]) $display("FAIL ovf_byte%0d: got %02h required %02h", k, got_q[k], exp_q[k]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    clear_run();
    bus.fifo_level = '0;
    @(negedge wr_clk);
    bus.pix_valid = 1'b1; bus.pix_sof = 1'b0; bus.pix_data = 8'h5C;
    while (got_q.size() < 6 && guard < 100) begin
      @(negedge wr_clk);
      guard++;
    end
    n_checks++; if (bus.wr_en !== 1'b1) $display("FAIL mid_precondition: wr_en %b required 1", bus.wr_en); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.wr_en, bus.din, bus.pix_ready, pkg_ready, frame_cnt, drop_cnt, sof_err, ovf_err, busy} !== '0)
      $display("FAIL mid_reset_async: wr_en %b din %02h pix_ready %b pkg_ready %b frame %0d drop %0d sof %b ovf %b busy %b required all 0",
               bus.wr_en, bus.din, bus.pix_ready, pkg_ready, frame_cnt, drop_cnt, sof_err, ovf_err, busy);
    else n_pass++;
    bus.pix_valid = 1'b0;
    @(negedge wr_clk);
    rst_n = 1'b1;
    model_reset();
    clear_run();
    for (int k = 0; k < P; k++) begin
      st_data.push_back(8'hC0 + 8'(k));
      st_sof.push_back(k == 0);
    end
    model_stream(0);
    drive_stream(0);
    wait_idle();
    n_checks++;
    if (got_q.size() !== exp_q.size()) $display("FAIL recover_len: got %0d required %0d", got_q.size(), exp_q.size()); else n_pass++;
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      n_checks++;
      if (got_q[k] !== exp_q[k]) $display("FAIL recover_byte%0d: got %02h required %02h", k, got_q[k], exp_q[k]); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_same_frame();
    test_en_gate();
    test_space_drop();
    test_boundary_admit();
    test_truncation();
    test_random();
    test_overflow();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/daq_pkg_scheduler.md
# daq_pkg_scheduler

Write-side controller for the DAQ_SPI packet FIFO, running in the `wr_clk` domain between the sensor line buffer and the async FIFO write port. It admits a package only when the FIFO has room for the whole package. It prefixes every package with a 4-byte header and streams the payload into the FIFO. It drops whole packages when space is short, and pads packages truncated by a new frame. This guarantees the SPI/WiFi read side only ever sees complete, fixed-size, self-describing packages.

## Interface
Parameters:
- `DATA_W`, 8, FIFO data width (header bytes are 8 bit).
- `ADDR_W`, 14, FIFO address width; capacity = 2^ADDR_W words.
- `PKG_PAYLOAD`, 4096, payload words per package (1..2^ADDR_W−4).

Ports (reset `rst_n`, asynchronous, active-low; clock `wr_clk`):
- `wr_clk` in 1: sole clock.
- `rst_n` in 1: async active-low reset.
- `en` in 1: admit new packages; sampled only in IDLE.
- `pix_valid` in 1: upstream beat valid.
- `pix_ready` out 1: beat accepted when `pix_valid && pix_ready` at a rising edge.
- `pix_data` in DATA_W: pixel word.
- `pix_sof` in 1: beat is the first pixel of a frame.
- `fifo_level` in ADDR_W+1: FIFO occupancy in words, wr_clk domain, may be pessimistic.
- `fifo_full` in 1: FIFO full flag.
- `wr_en` out 1: FIFO write strobe (registered).
- `din` out DATA_W: FIFO write data (registered).
- `pkg_ready` out 1: one-cycle pulse per committed package.
- `frame_cnt` out 8: current frame number.
- `drop_cnt` out 16: dropped-package count, saturating.
- `sof_err` out 1: sticky, a package was padded.
- `ovf_err` out 1: sticky, a write was issued while `fifo_full`.
- `busy` out 1: state ≠ IDLE.

## Operation
- `free = 2^ADDR_W − fifo_level`, computed (ADDR_W+2) bits wide.
- The block admits a package when `free ≥ PKG_PAYLOAD+4`.
- States: IDLE, HDR, PAYLOAD, PAD, DROP, DONE.
- **IDLE:** `pix_ready=0`.
  - If `en && pix_valid` and the space check passes: go to HDR.
  - If `en && pix_valid` and the check fails: go to DROP.
  - If the pending beat has `pix_sof`, then on that same transition `frame_cnt++` (mod 256) and `pkg_idx` clears to 0.
  - The sof beat itself is consumed later, as the first payload or drop beat.
- **HDR:** 4 cycles, `pix_ready=0`. Writes 0xA5, 0x5A, `frame_cnt`, `pkg_idx`, in that order, then goes to PAYLOAD with `beat_cnt=0`.
- **PAYLOAD:**
  - `pix_ready = !(pix_sof && beat_cnt≠0)` (combinational).
  - Each accepted beat is written and increments `beat_cnt`.
  - After beat number `PKG_PAYLOAD` is accepted: go to DONE.
  - If `pix_valid && pix_sof && beat_cnt≠0`: go to PAD, set `sof_err`, and leave the sof beat unaccepted.
- **PAD:** `pix_ready=0`. Writes 0x00 each cycle until `beat_cnt = PKG_PAYLOAD`, then goes to DONE.
- **DROP:**
  - `pix_ready=1`, no writes.
  - Accepted beats are discarded until `PKG_PAYLOAD` beats have been consumed.
  - A sof beat with `beat_cnt≠0` is not accepted and ends the drop early.
  - On exit: `drop_cnt++` (saturate at 0xFFFF), `pkg_idx++` (mod 256), go to IDLE.
- **DONE:** one cycle. Sets `pkg_ready` next cycle, `pkg_idx++` (mod 256), go to IDLE.
- `ovf_err` is set whenever `wr_en && fifo_full`. The write is still issued; the FIFO ignores it.
- `en` deasserted mid-package has no effect until IDLE.
- Reset mid-operation: immediate return to IDLE. A partial package already in the FIFO is not recovered; the FIFO is reset by the same `rst_n`.

## Timing
- Reset values: `wr_en=0`, `din=0`, `pix_ready=0`, `pkg_ready=0`, `frame_cnt=0`, `drop_cnt=0`, `sof_err=0`, `ovf_err=0`, `busy=0`. Internal `pkg_idx=0`, `beat_cnt=0`.
- Space check at edge E0 (IDLE): header bytes appear on `wr_en`/`din` in cycles E0+2 .. E0+5.
- A payload beat accepted at edge E appears on `wr_en`/`din` in the cycle after E.
- With continuous `pix_valid`, payload writes are back-to-back.
- `pkg_ready` is high for exactly one cycle, the cycle immediately after the last payload/pad `wr_en` cycle.
- Minimum package period: 1 (IDLE) + 4 + PKG_PAYLOAD + 1 (DONE) cycles.
- `fifo_level` is sampled only in IDLE. Its pessimism can only cause extra drops, never overflow.

## Test plan
(PKG_PAYLOAD=8, ADDR_W=5, capacity 32 unless noted)
- **Basic package:** reset, `en=1`, `fifo_level=0`, continuous beats 0x01..0x08, first with `pix_sof`.
  - FIFO receives A5 5A 01 00 01..08 on 12 consecutive `wr_en` cycles.
  - `pkg_ready` pulses once, the cycle after 0x08.
  - `frame_cnt=1`.
- **Second package, same frame:** continue with beats 0x09..0x10, no sof.
  - Header A5 5A 01 01, then payload 0x09..0x10.
  - `frame_cnt` unchanged.
- **Space drop:** `fifo_level=21` (free 11 < 12), pix_valid.
  - 8 beats consumed, `wr_en` never high.
  - `drop_cnt=1`, no `pkg_ready`, next package header carries `pkg_idx` incremented.
- **Boundary admit:** `fifo_level=20` (free 12) → package admitted and written fully.
- **Truncation:** `pix_sof` beat presented after 3 payload beats.
  - `pix_ready=0` for it; 5 bytes 0x00 written; `sof_err=1`; `pkg_ready` pulses.
  - Next header shows `frame_cnt+1`, `pkg_idx=0`, and the sof pixel is the first payload byte.
- **Reset mid-payload and overflow flag:**
  - Assert `rst_n=0` during PAYLOAD: all outputs return to reset values asynchronously.
  - Separately, force `fifo_full=1` during payload: `ovf_err=1` and it remains set.
